// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master arbiter/sequencer for the shared data-memory port
module dbus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int WR_TIMEOUT = 16,
  parameter int TO_W       = 5
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_acc_i,
  input  logic        m0_sext_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_wdone_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_acc_i,
  input  logic        m1_sext_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_wdone_o,
  output logic        m1_err_o,
  output logic        s_r_en_o,
  output logic        s_wr_en_o,
  output logic [1:0]  s_acc_o,
  output logic        s_sext_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_wr_ready_i
);
  typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;
  state_t            state;
  logic              owner;
  logic              last_grant;
  logic [1:0]        acc_q;
  logic              sext_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [TO_W-1:0]   cnt;
  logic              any_req;
  logic              win;
  logic              busy;
  logic              to_hit;
  assign any_req  = m0_req_i | m1_req_i;
  assign win      = (m0_req_i & m1_req_i) ? (FIXED_PRIO ? 1'b0 : ~last_grant) : m1_req_i;
  assign m0_gnt_o = rstn_i & (state == IDLE) & any_req & ~win;
  assign m1_gnt_o = rstn_i & (state == IDLE) & any_req & win;
  assign s_r_en_o  = state == RD;
  assign s_wr_en_o = state == WR;
  assign busy      = s_r_en_o | s_wr_en_o;
  assign s_acc_o   = busy ? acc_q : 2'b0;
  assign s_sext_o  = busy & sext_q;
  assign s_addr_o  = busy ? addr_q : 32'b0;
  assign s_wdata_o = s_wr_en_o ? wdata_q : 32'b0;
  assign to_hit    = cnt == TO_W'(WR_TIMEOUT - 1);
  // Sequencer: latch the winner's command, run the slave access, pulse completion to the owner
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      acc_q       <= '0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rdata_o  <= '0;
      m0_wdone_o  <= 1'b0;
      m1_wdone_o  <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
    end else begin
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_wdone_o  <= 1'b0;
      m1_wdone_o  <= 1'b0;
      m0_err_o    <= 1'b0;
      m1_err_o    <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          owner      <= win;
          last_grant <= win;
          acc_q      <= win ? m1_acc_i : m0_acc_i;
          sext_q     <= win ? m1_sext_i : m0_sext_i;
          addr_q     <= win ? m1_addr_i : m0_addr_i;
          wdata_q    <= win ? m1_wdata_i : m0_wdata_i;
          state      <= (win ? m1_we_i : m0_we_i) ? WR : RD;
        end
        RD: state <= RSP;
        RSP: begin
          if (owner) begin
            m1_rdata_o  <= s_rdata_i;
            m1_rvalid_o <= 1'b1;
          end else begin
            m0_rdata_o  <= s_rdata_i;
            m0_rvalid_o <= 1'b1;
          end
          state <= IDLE;
        end
        WR: if (s_wr_ready_i || to_hit) begin
          m0_wdone_o <= ~owner;
          m1_wdone_o <= owner;
          m0_err_o   <= ~owner & ~s_wr_ready_i;
          m1_err_o   <= owner & ~s_wr_ready_i;
          cnt        <= '0;
          state      <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
Two-master arbiter/sequencer for the shared data-memory port driven by mem_control. Master 0 is the CPU load/store path. Master 1 is the USB debug/loader engine, which reads and writes data memory while the program runs. The block arbitrates requests, latches the winning command, sequences the single-cycle-latency read and the ready-gated write on the slave port, and returns completion, with a write timeout guard.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins on conflict
WR_TIMEOUT, 16, max cycles s_wr_en_o is held waiting for s_wr_ready_i before abort (>=1)
TO_W, 5, width of timeout counter; must hold WR_TIMEOUT

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
m0_req_i / m1_req_i  in  1  request valid; held until gnt
m0_we_i / m1_we_i  in  1  1 = write, 0 = read
m0_acc_i / m1_acc_i  in  2  access size (byte/half/word encoding shared with mem_control)
m0_sext_i / m1_sext_i  in  1  sign-extend read data
m0_addr_i / m1_addr_i  in  32  byte address
m0_wdata_i / m1_wdata_i  in  32  write data
m0_gnt_o / m1_gnt_o  out  1  one-cycle accept pulse; command sampled this cycle
m0_rvalid_o / m1_rvalid_o  out  1  one-cycle read-data-valid pulse
m0_rdata_o / m1_rdata_o  out  32  read data, valid with rvalid
m0_wdone_o / m1_wdone_o  out  1  one-cycle write-complete pulse
m0_err_o / m1_err_o  out  1  one-cycle pulse with wdone when write timed out
s_r_en_o  out  1  slave read enable
s_wr_en_o  out  1  slave write enable
s_acc_o  out  2  slave access size
s_sext_o  out  1  slave sign-extend
s_addr_o  out  32  slave address
s_wdata_o  out  32  slave write data
s_rdata_i  in  32  slave read data, valid 1 cycle after s_r_en_o
s_wr_ready_i  in  1  slave write accepted this cycle

Behaviour:
- Reset (async, rstn_i low): state=IDLE; all *_o = 0; last_grant=1, so master 0 wins the first conflict; timeout counter = 0. Reset mid-transaction drops the transaction silently: no rvalid, no wdone.
- States: IDLE, RD, RSP, WR.
- IDLE:
  - If any req, pick winner:
    - only one requesting -> that one;
    - both, FIXED_PRIO=1 -> m0;
    - both, FIXED_PRIO=0 -> master != last_grant.
  - gnt_o of the winner is combinational and high in this cycle only.
  - Latch owner, we, acc, sext, addr, wdata; update last_grant.
  - Next state: RD if we=0, else WR.
  - No req -> stay IDLE.
- RD (1 cycle): s_r_en_o=1 with latched fields; next RSP.
- RSP: register s_rdata_i into owner's rdata; owner rvalid_o=1 in the following cycle (registered); next IDLE.
- WR:
  - s_wr_en_o=1, latched fields held stable; counter increments each cycle.
  - If s_wr_ready_i=1 -> owner wdone_o pulses next cycle; next IDLE.
  - Else if counter == WR_TIMEOUT-1 -> drop s_wr_en_o; wdone_o and err_o pulse next cycle; next IDLE.
  - Counter clears on WR exit.
- Timing, grant at cycle T:
  - read: s_r_en_o at T+1, s_rdata_i sampled at T+2, rvalid/rdata at T+3;
  - write: s_wr_en_o from T+1, wdone one cycle after the s_wr_ready_i cycle.
- Throughput: the next grant is possible in the cycle state returns to IDLE. That is the same cycle as a pulsed rvalid/wdone, so back-to-back reads cost 3 cycles each.
- Slave outputs are 0 when not in RD/WR, so s_addr_o does not leak into the decode of the OR-ed bus.
- rdata_o holds its value until the next read by that master; only the owner's outputs ever pulse.
- Request dropped before gnt: no effect. Requests arriving while busy wait; no queueing beyond holding req.
- Round-robin is fair: alternating grants under continuous contention.

Test Plan:
- Reset then m0 read addr 0x100, slave returns 0xDEADBEEF -> m0_gnt_o at T, s_r_en_o & s_addr_o=0x100 at T+1, m0_rvalid_o & m0_rdata_o=0xDEADBEEF at T+3; m1 outputs stay 0.
- m1 write 0x204←0x12345678, s_wr_ready_i asserted after 3 wait cycles -> s_wr_en_o high 4 cycles with stable addr/data, m1_wdone_o one pulse, m1_err_o=0.
- Both masters request reads every cycle, FIXED_PRIO=0 -> grants m0,m1,m0,m1 (m0 first after reset); with FIXED_PRIO=1 -> m0 only while m0_req_i held.
- Write with s_wr_ready_i never asserted, WR_TIMEOUT=16 -> s_wr_en_o high exactly 16 cycles, then wdone_o and err_o pulse together, state back to IDLE.
- rstn_i pulsed low during WR -> all outputs 0 immediately; no wdone after release; next request is granted normally.
- m0 write immediately followed by m0 read of same address -> read is granted the cycle wdone pulses and returns the written data.
